trng_collector: RTL and testbench
=================================

Name: trng_collector

Overview:
Parametrised successor to the single-source 8-bit TRNG. It samples NUM_SRC external ring-oscillator taps, XOR-combines them, and optionally removes bias with a von Neumann corrector. A repetition-count health test guards the raw stream, and bits are assembled into OUT_WIDTH-bit words delivered over a valid/ready handshake. It sits between the oscillator bank and the consumer, such as a key-generation or CSPRNG seed interface.

Parameters:
NUM_SRC, 4, number of asynchronous entropy inputs (1..32)
OUT_WIDTH, 8, bits per output word (2..64)
REP_LIMIT, 16, raw run length that trips the health test (2..255)
DEBIAS, 1, 1 = von Neumann corrector enabled, 0 = raw bits pass straight through

Ports:
clk  in  1  system clock
n_reset  in  1  asynchronous active-low reset
enable  in  1  level; collection runs while high
entropy_in  in  NUM_SRC  asynchronous ring-oscillator taps
clear_fail  in  1  single-cycle pulse; clears a latched health failure
rand_data  out  OUT_WIDTH  assembled random word
rand_valid  out  1  rand_data holds an unconsumed word
rand_ready  in  1  consumer accepts rand_data when asserted with rand_valid
health_fail  out  1  sticky repetition-test failure flag

Behaviour:
- Reset (async, n_reset=0):
  - All registers clear: sync flops, raw_q, run counter, pair state, accumulator, bit count.
  - Outputs: rand_data=0, rand_valid=0, health_fail=0. FSM enters IDLE.
- Pipeline:
  - entropy_in passes through a 2-flop synchroniser per bit.
  - raw_q is the registered XOR-reduce of sync stage 2.
  - A sample at edge k is in raw_q after edge k+2 and can enter the accumulator at edge k+3.
- FSM states:
  - IDLE -> COLLECT when enable=1.
  - COLLECT -> IDLE when enable=0. Clears accumulator, bit count, pair state and run counter; the output register is retained.
  - COLLECT -> FAIL on a health trip.
  - FAIL -> IDLE on clear_fail=1. clear_fail is ignored in other states.
- Run counter (COLLECT only, one raw_q per cycle):
  - First raw_q after entering COLLECT sets count=1.
  - Equal to the previous raw_q: count+1, saturating. Different: count=1.
  - When the count reaches REP_LIMIT: health_fail=1, rand_valid=0 (pending word flushed), accumulator discarded, FSM enters FAIL. The tripping bit is not accumulated.
- Debias, DEBIAS=1:
  - raw bits are taken in pairs (first, second).
  - first != second: emit first. Equal: emit nothing.
  - Pair state resets on IDLE or FAIL entry.
- Debias, DEBIAS=0: every raw_q in COLLECT is emitted.
- Assembly:
  - An emitted bit shifts into the LSB: acc <= {acc[OUT_WIDTH-2:0], bit}.
  - On the OUT_WIDTH-th bit, {acc[OUT_WIDTH-2:0], bit} loads straight into rand_data on the same edge and rand_valid=1, if the output register is free or is being consumed that cycle. The count then resets to 0.
  - If the output register is full and not consumed, the completed word stays in the accumulator (held full). Further emitted bits are dropped until the transfer occurs; the run counter keeps operating.
- Handshake:
  - A transfer occurs when rand_valid & rand_ready on an edge.
  - rand_data is stable while rand_valid=1 and rand_ready=0.
  - Transfer plus a simultaneous new word: rand_valid stays 1 and rand_data updates.
  - A held accumulator word moves to the output on the transfer edge.
  - rand_valid never depends combinationally on rand_ready.
- health_fail stays high until clear_fail is pulsed in FAIL. enable is ignored while in FAIL.
- Throughput: at most one word per OUT_WIDTH cycles with DEBIAS=0, and at most one per 2*OUT_WIDTH cycles with DEBIAS=1.

Test Plan:
- Reset mid-operation:
  - Stimulus: pull n_reset low with rand_valid=1 and a partial word.
  - Response: rand_valid=0, rand_data=0, health_fail=0 immediately (asynchronously); after release, no word until OUT_WIDTH fresh bits have been emitted.
- DEBIAS=0 assembly:
  - Stimulus: NUM_SRC=4, rand_ready=1, drive entropy_in so the XOR sequence is 1,0,1,1,0,0,1,0.
  - Response: rand_data=8'hB2, rand_valid high for 1 cycle, 3 cycles after the last sample edge.
- DEBIAS=1 corrector:
  - Stimulus: XOR pairs 10,01,11,00,10,10,01,01,10,01.
  - Response: emitted bits 1,0,1,1,0,0,1,0, giving rand_data=8'hB2; the 11 and 00 pairs are discarded.
- Backpressure:
  - Stimulus: rand_ready=0, alternating entropy for 3 words' worth of bits.
  - Response: first word held stable on rand_data, second word held in the accumulator, third word's bits dropped; raising rand_ready delivers exactly words 1 then 2.
- Health trip:
  - Stimulus: DEBIAS=0, REP_LIMIT=16, entropy_in constant 0, rand_ready=0.
  - Response: rand_valid=1 with 8'h00 after raw bit 8; at raw bit 16, health_fail=1, rand_valid=0, no further words. clear_fail plus alternating input resumes output.
- Enable toggle:
  - Stimulus: drop enable after 5 of 8 bits, then raise it again.
  - Response: the partial bits are discarded; the next word contains only post-re-enable bits; a pending rand_data survives the toggle.

Source files
------------

// File: rtl/trng_collector.sv
// Multi-source TRNG collector: synchronise and XOR-combine oscillator taps, optional
// von Neumann debiasing, repetition-count health test, word assembly with valid/ready output.
module trng_collector #(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned REP_LIMIT = 16,
  parameter int unsigned DEBIAS    = 1
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 enable,
  input  logic [NUM_SRC-1:0]   entropy_in,
  input  logic                 clear_fail,
  output logic [OUT_WIDTH-1:0] rand_data,
  output logic                 rand_valid,
  input  logic                 rand_ready,
  output logic                 health_fail
);

  localparam int unsigned CW = $clog2(OUT_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, FAIL} state_t;

  state_t               state;
  logic [NUM_SRC-1:0]   sync1, sync2;
  logic                 raw_q, prev_raw;
  logic                 pair_have, pair_first;
  logic [7:0]           run_cnt, run_next;
  logic [OUT_WIDTH-1:0] acc, word;
  logic [CW-1:0]        bit_cnt;
  logic                 emit, emit_bit, trip, xfer, out_free, acc_full, last_bit;

  always_comb begin
    run_next = 8'd1;
    if (run_cnt != '0 && raw_q == prev_raw)
      run_next = (run_cnt == '1) ? run_cnt : run_cnt + 8'd1;
    trip = run_next >= 8'(REP_LIMIT);
    if (DEBIAS != 0) begin
      emit     = pair_have && (raw_q != pair_first);
      emit_bit = pair_first;
    end else begin
      emit     = 1'b1;
      emit_bit = raw_q;
    end
    word     = {acc[OUT_WIDTH-2:0], emit_bit};
    xfer     = rand_valid && rand_ready;
    out_free = !rand_valid || rand_ready;
    acc_full = bit_cnt == CW'(OUT_WIDTH);
    last_bit = bit_cnt == CW'(OUT_WIDTH - 1);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= IDLE;
      sync1       <= '0;
      sync2       <= '0;
      raw_q       <= 1'b0;
      prev_raw    <= 1'b0;
      pair_have   <= 1'b0;
      pair_first  <= 1'b0;
      run_cnt     <= '0;
      acc         <= '0;
      bit_cnt     <= '0;
      rand_data   <= '0;
      rand_valid  <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      sync1 <= entropy_in;
      sync2 <= sync1;
      raw_q <= ^sync2;
      case (state)
        IDLE: begin
          if (xfer) rand_valid <= 1'b0;
          if (enable) state <= COLLECT;
        end
        COLLECT: begin
          if (!enable) begin
            state     <= IDLE;
            run_cnt   <= '0;
            pair_have <= 1'b0;
            acc       <= '0;
            bit_cnt   <= '0;
            if (xfer) rand_valid <= 1'b0;
          end else if (trip) begin
            // Tripping bit is not accumulated; any pending word is flushed.
            state       <= FAIL;
            health_fail <= 1'b1;
            rand_valid  <= 1'b0;
            run_cnt     <= '0;
            pair_have   <= 1'b0;
            acc         <= '0;
            bit_cnt     <= '0;
          end else begin
            run_cnt  <= run_next;
            prev_raw <= raw_q;
            if (DEBIAS != 0) begin
              pair_have <= !pair_have;
              if (!pair_have) pair_first <= raw_q;
            end
            if (xfer) rand_valid <= 1'b0;
            // A held word drains first; bits emitted while held are dropped.
            if (acc_full) begin
              if (out_free) begin
                rand_data  <= acc;
                rand_valid <= 1'b1;
                bit_cnt    <= '0;
              end
            end else if (emit) begin
              if (last_bit && out_free) begin
                rand_data  <= word;
                rand_valid <= 1'b1;
                bit_cnt    <= '0;
              end else begin
                acc     <= word;
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
          end
        end
        FAIL: begin
          if (xfer) rand_valid <= 1'b0;
          if (clear_fail) begin
            health_fail <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trng_collector.sv
// Bench for trng_collector: raw-bypass and debiased instances share stimulus and are
// checked every cycle against a bit-queue model plus directed expectations.
module tb_trng_collector;

  localparam int W = 8;
  localparam int REP = 16;

  logic         clk, n_reset, enable, clear_fail, rand_ready;
  logic [3:0]   entropy_in;
  logic [W-1:0] rd0, rd1;
  logic         rv0, rv1, hf0, hf1;

  int total = 0;
  int bad   = 0;

  trng_collector #(.NUM_SRC(4), .OUT_WIDTH(W), .REP_LIMIT(REP), .DEBIAS(0)) dut0 (
    .clk(clk), .n_reset(n_reset), .enable(enable), .entropy_in(entropy_in),
    .clear_fail(clear_fail), .rand_data(rd0), .rand_valid(rv0),
    .rand_ready(rand_ready), .health_fail(hf0));

  trng_collector #(.NUM_SRC(4), .OUT_WIDTH(W), .REP_LIMIT(REP), .DEBIAS(1)) dut1 (
    .clk(clk), .n_reset(n_reset), .enable(enable), .entropy_in(entropy_in),
    .clear_fail(clear_fail), .rand_data(rd1), .rand_valid(rv1),
    .rand_ready(rand_ready), .health_fail(hf1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: index 0 = raw bypass, index 1 = von Neumann.
  bit         ph [3];
  bit         m_on [2], m_fail [2], m_valid [2], m_last [2], m_have [2], m_first [2];
  int         m_run [2], m_n [2];
  bit [W-1:0] m_acc [2], m_out [2];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) ph[i] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_on[d] = 0; m_fail[d] = 0; m_valid[d] = 0; m_last[d] = 0;
      m_have[d] = 0; m_first[d] = 0; m_run[d] = 0; m_n[d] = 0;
      m_acc[d] = '0; m_out[d] = '0;
    end
  endtask

  task automatic model_step(int d, bit raw);
    bit xfer, emit, eb;
    xfer = m_valid[d] && rand_ready;
    emit = 0;
    eb   = 0;
    if (m_fail[d]) begin
      if (xfer) m_valid[d] = 0;
      if (clear_fail) m_fail[d] = 0;
    end else if (!m_on[d]) begin
      if (xfer) m_valid[d] = 0;
      if (enable) m_on[d] = 1;
    end else if (!enable) begin
      if (xfer) m_valid[d] = 0;
      m_on[d] = 0; m_run[d] = 0; m_have[d] = 0; m_n[d] = 0; m_acc[d] = '0;
    end else begin
      if (m_run[d] == 0 || raw != m_last[d]) m_run[d] = 1;
      else if (m_run[d] < 255) m_run[d] = m_run[d] + 1;
      m_last[d] = raw;
      if (m_run[d] >= REP) begin
        m_fail[d] = 1; m_on[d] = 0; m_valid[d] = 0;
        m_run[d] = 0; m_have[d] = 0; m_n[d] = 0; m_acc[d] = '0;
      end else begin
        if (d == 1) begin
          if (!m_have[d]) begin
            m_have[d] = 1; m_first[d] = raw;
          end else begin
            m_have[d] = 0;
            if (raw != m_first[d]) begin emit = 1; eb = m_first[d]; end
          end
        end else begin
          emit = 1; eb = raw;
        end
        if (xfer) m_valid[d] = 0;
        if (m_n[d] == W) begin
          if (!m_valid[d]) begin m_out[d] = m_acc[d]; m_valid[d] = 1; m_n[d] = 0; end
        end else if (emit) begin
          m_acc[d] = (m_acc[d] << 1) | W'(eb);
          m_n[d]   = m_n[d] + 1;
          if (m_n[d] == W && !m_valid[d]) begin
            m_out[d] = m_acc[d]; m_valid[d] = 1; m_n[d] = 0;
          end
        end
      end
    end
  endtask

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      model_reset();
    end else begin
      bit raw;
      raw   = ph[2];
      ph[2] = ph[1];
      ph[1] = ph[0];
      ph[0] = ^entropy_in;
      for (int d = 0; d < 2; d++) model_step(d, raw);
    end
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("valid0",  64'(rv0), 64'(m_valid[0]));
    chk("data0",   64'(rd0), 64'(m_out[0]));
    chk("health0", 64'(hf0), 64'(m_fail[0]));
    chk("valid1",  64'(rv1), 64'(m_valid[1]));
    chk("data1",   64'(rd1), 64'(m_out[1]));
    chk("health1", 64'(hf1), 64'(m_fail[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic set_bit(bit b);
    logic [3:0] r;
    r = 4'($urandom);
    r[0] = r[0] ^ (^r) ^ b;
    entropy_in = r;
  endtask

  initial begin
    bit         pat0 [8]  = '{1,0,1,1,0,0,1,0};
    bit         pat1 [20] = '{1,0,0,1,1,1,0,0,1,0,1,0,0,1,0,1,1,0,0,1};
    bit [W-1:0] snap;
    bit         have;
    int         seen;

    n_reset = 1'b0; enable = 1'b0; clear_fail = 1'b0; rand_ready = 1'b1;
    entropy_in = '0;
    repeat (3) tick();
    chk("reset_data0", 64'(rd0), 64'h0);
    chk("reset_valid1", 64'(rv1), 64'h0);
    n_reset = 1'b1;
    tick();

    // Raw assembly: XOR stream 1,0,1,1,0,0,1,0 -> 8'hB2 three edges after the last sample.
    for (int i = 0; i < 8; i++) begin
      set_bit(pat0[i]);
      enable = (i >= 2);
      tick();
    end
    for (int j = 0; j < 3; j++) begin
      set_bit(j[0]);
      tick();
    end
    chk("b2_raw_valid", 64'(rv0), 64'h1);
    chk("b2_raw_data",  64'(rd0), 64'hB2);
    set_bit(1'b1);
    tick();
    chk("b2_raw_one_cycle", 64'(rv0), 64'h0);

    // Von Neumann: pairs 10,01,11,00,10,10,01,01,10,01 -> 8'hB2.
    enable = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      set_bit(pat1[i]);
      enable = (i >= 2);
      tick();
    end
    for (int j = 0; j < 3; j++) begin
      set_bit(j[0]);
      tick();
    end
    chk("b2_vn_valid", 64'(rv1), 64'h1);
    chk("b2_vn_data",  64'(rd1), 64'hB2);

    // Backpressure: held output must stay stable.
    rand_ready = 1'b0;
    have = 0;
    snap = '0;
    for (int i = 0; i < 60; i++) begin
      set_bit(1'($urandom));
      tick();
      if (have) chk("hold_stable0", 64'(rd0), 64'(snap));
      else if (m_valid[0]) begin have = 1; snap = m_out[0]; end
    end
    rand_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_bit(1'($urandom));
      tick();
    end

    // Health trip on a constant-zero stream.
    enable = 1'b0;
    repeat (2) tick();
    rand_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_bit(1'b0);
      enable = (i >= 2);
      tick();
      if (i == 10) begin
        chk("zero_word_valid", 64'(rv0), 64'h1);
        chk("zero_word_data",  64'(rd0), 64'h0);
      end
      if (i == 17) chk("pre_trip_health", 64'(hf0), 64'h0);
      if (i == 18) begin
        chk("trip_health0", 64'(hf0), 64'h1);
        chk("trip_health1", 64'(hf1), 64'h1);
        chk("trip_flush",   64'(rv0), 64'h0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      enable = i[0];
      set_bit(i[1]);
      tick();
    end
    chk("fail_sticky", 64'(hf0), 64'h1);
    enable = 1'b1;
    clear_fail = 1'b1;
    tick();
    clear_fail = 1'b0;
    chk("fail_cleared", 64'(hf0), 64'h0);
    rand_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      set_bit(i[0]);
      tick();
      if (rv0) seen++;
    end
    chk("resume_output", 64'(seen > 0), 64'h1);

    // Enable toggle keeps the pending output word.
    rand_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      set_bit(1'($urandom));
      tick();
    end
    snap = m_out[0];
    enable = 1'b0;
    repeat (2) tick();
    enable = 1'b1;
    repeat (2) tick();
    chk("toggle_keep_valid", 64'(rv0), 64'h1);
    chk("toggle_keep_data",  64'(rd0), 64'(snap));
    for (int i = 0; i < 5; i++) begin
      set_bit(1'($urandom));
      tick();
    end

    // Asynchronous reset mid-operation.
    #1 n_reset = 1'b0;
    #1;
    chk("async_rst_valid0", 64'(rv0), 64'h0);
    chk("async_rst_data0",  64'(rd0), 64'h0);
    chk("async_rst_data1",  64'(rd1), 64'h0);
    chk("async_rst_health", 64'(hf0), 64'h0);
    #5 n_reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_bit(1'($urandom));
      tick();
    end

    // Random soak.
    for (int i = 0; i < 400; i++) begin
      enable     = ($urandom_range(0, 19) != 0);
      rand_ready = 1'($urandom);
      clear_fail = ($urandom_range(0, 19) == 0);
      set_bit(1'($urandom));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
